// File: rtl/pcs_tx_ordered_set_gen.sv
// 1000BASE-X PCS transmit code-group generator.
// Turns a GMII-style octet stream (txd/tx_en/tx_er) into unencoded code groups
// for the 8b/10b encoder: /I/ idles, /S/, data, /V/, /T/R/ with even-alignment
// /R/, carrier-extension /R/ and frame bursts (/R/R/S/).
// All outputs are registered; the word seen after edge n derives from the
// inputs sampled at edge n.
module pcs_tx_ordered_set_gen #(
   parameter int         CNT_W  = 16,
   parameter logic [7:0] IDLE_D = 8'h50,
   parameter logic [7:0] CEXT_D = 8'h0F
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       txd,
   input  logic             tx_en,
   input  logic             tx_er,
   output logic [7:0]       tx_data,
   output logic             tx_datak,
   output logic             tx_even,
   output logic [CNT_W-1:0] frame_cnt,
   output logic             drop_octet
);

   localparam logic [7:0]       K28_5   = 8'hBC;
   localparam logic [7:0]       K_START = 8'hFB;
   localparam logic [7:0]       K_TERM  = 8'hFD;
   localparam logic [7:0]       K_CEXT  = 8'hF7;
   localparam logic [7:0]       K_ERR   = 8'hFE;
   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   typedef enum logic [2:0] {
      IDLE,
      DATA,
      END_R,
      EXTEND,
      END_R2
   } state_t;

   state_t     state, state_nxt;
   logic       idle_ok, idle_ok_nxt;
   logic [7:0] data_nxt;
   logic       datak_nxt;
   logic       drop_nxt;
   logic       cnt_inc;
   logic       next_even;
   logic       cext_in;

   // The word being computed lands in the slot opposite to the current one.
   assign next_even = ~tx_even;
   assign cext_in   = ~tx_en & tx_er;

   // Next-state and next-word decode; /S/ only ever goes into an even slot.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
      state_nxt   = state;
      idle_ok_nxt = idle_ok;
      data_nxt    = K_CEXT;
      datak_nxt   = 1'b1;
      drop_nxt    = 1'b0;
      cnt_inc     = 1'b0;
      unique case (state)
         IDLE: begin
            if (next_even) begin
               if (tx_en && idle_ok) begin
                  data_nxt  = K_START;
                  cnt_inc   = 1'b1;
                  state_nxt = DATA;
               end else begin
                  data_nxt = K28_5;
                  drop_nxt = tx_en;
               end
            end else begin
               // Second half of /I/: a full idle has now been sent.
               data_nxt    = IDLE_D;
               datak_nxt   = 1'b0;
               idle_ok_nxt = 1'b1;
               drop_nxt    = tx_en;
            end
         end
         DATA: begin
            if (tx_en) begin
               if (tx_er) begin
                  data_nxt = K_ERR;
               end else begin
                  data_nxt  = txd;
                  datak_nxt = 1'b0;
               end
            end else begin
               data_nxt    = K_TERM;
               idle_ok_nxt = 1'b0;
               state_nxt   = END_R;
            end
         end
         END_R: begin
            drop_nxt = tx_en;
            if (cext_in)        state_nxt = EXTEND;
            else if (next_even) state_nxt = END_R2;
            else                state_nxt = IDLE;
         end
         EXTEND: begin
            if (tx_en) begin
               if (next_even) begin
                  // Burst: the next frame may start without an idle.
                  data_nxt  = K_START;
                  cnt_inc   = 1'b1;
                  state_nxt = DATA;
               end else begin
                  drop_nxt = 1'b1;
               end
            end else if (tx_er) begin
               if (txd != CEXT_D) data_nxt = K_ERR;
            end else if (next_even) begin
               state_nxt = END_R2;
            end else begin
               state_nxt = IDLE;
            end
         end
         END_R2: begin
            drop_nxt  = tx_en;
            state_nxt = IDLE;
         end
         default: begin
            data_nxt  = K28_5;
            state_nxt = IDLE;
         end
      endcase
   end

   // Output and state registers; reset aborts any frame in progress.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state      <= IDLE;
         idle_ok    <= 1'b0;
         tx_data    <= K28_5;
         tx_datak   <= 1'b1;
         tx_even    <= 1'b1;
         frame_cnt  <= '0;
         drop_octet <= 1'b0;
      end else begin
         state      <= state_nxt;
         idle_ok    <= idle_ok_nxt;
         tx_data    <= data_nxt;
         tx_datak   <= datak_nxt;
         tx_even    <= ~tx_even;
         drop_octet <= drop_nxt;
         if (cnt_inc) frame_cnt <= frame_cnt + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_pcs_tx_ordered_set_gen.sv
// Directed bench for pcs_tx_ordered_set_gen. Each scenario builds a table of
// input vectors with hand-derived expected words and replays it cycle by cycle.
module tb_pcs_tx_ordered_set_gen;

   localparam logic [8:0] W_I = 9'h1BC;
   localparam logic [8:0] W_D = 9'h050;
   localparam logic [8:0] W_S = 9'h1FB;
   localparam logic [8:0] W_T = 9'h1FD;
   localparam logic [8:0] W_R = 9'h1F7;
   localparam logic [8:0] W_V = 9'h1FE;

   typedef struct {
      logic        rst;
      logic        en;
      logic        er;
      logic [7:0]  d;
      logic [8:0]  w;
      logic        dr;
      logic [15:0] cnt;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  txd = 8'h00;
   logic        tx_en = 1'b0;
   logic        tx_er = 1'b0;
   logic [7:0]  tx_data;
   logic        tx_datak;
   logic        tx_even;
   logic [15:0] frame_cnt;
   logic        drop_octet;

   int   errors = 0;
   int   checks = 0;
   vec_t q[$];

   always #5 clk = ~clk;

   pcs_tx_ordered_set_gen dut (
      .clk        (clk),
      .rst        (rst),
      .txd        (txd),
      .tx_en      (tx_en),
      .tx_er      (tx_er),
      .tx_data    (tx_data),
      .tx_datak   (tx_datak),
      .tx_even    (tx_even),
      .frame_cnt  (frame_cnt),
      .drop_octet (drop_octet)
   );

   task automatic add(input logic r, input logic en, input logic er, input logic [7:0] d,
                      input logic [8:0] w, input logic dr, input logic [15:0] cnt);
      vec_t v;
      v.rst = r; v.en = en; v.er = er; v.d = d; v.w = w; v.dr = dr; v.cnt = cnt;
      q.push_back(v);
   endtask

   // Octets first..n-1 of a preamble-style frame (last one D5) passed through as data.
   task automatic add_body(input int first, input int n, input int er_at, input logic [15:0] cnt);
      for (int i = first; i < n; i++) begin
         logic [7:0] d;
         d = (i == n - 1) ? 8'hD5 : 8'h55;
         if (i == er_at) add(1'b0, 1'b1, 1'b1, d, W_V, 1'b0, cnt);
         else            add(1'b0, 1'b1, 1'b0, d, {1'b0, d}, 1'b0, cnt);
      end
   endtask

   task automatic add_idle(input logic [8:0] w, input logic [15:0] cnt);
      add(1'b0, 1'b0, 1'b0, 8'h00, w, 1'b0, cnt);
   endtask

   task automatic test_reset();
      logic exp_ev;
      q.delete();
      for (int i = 0; i < 3; i++) add(1'b1, 1'b0, 1'b0, 8'h00, W_I, 1'b0, 16'd0);
      for (int i = 0; i < 6; i++) add_idle((i % 2 == 0) ? W_D : W_I, 16'd0);
      exp_ev = 1'b0;
      foreach (q[i]) begin
         rst = q[i].rst; tx_en = q[i].en; tx_er = q[i].er; txd = q[i].d;
         @(posedge clk); #1;
         exp_ev = q[i].rst ? 1'b1 : ~exp_ev;
         checks++;
         if ({tx_datak, tx_data} !== q[i].w || drop_octet !== q[i].dr ||
             tx_even !== exp_ev || frame_cnt !== q[i].cnt) begin
            errors++;
            $display("FAIL reset[%0d]: got k/d=%h drop=%b even=%b cnt=%0d, want k/d=%h drop=%b even=%b cnt=%0d",
                     i, {tx_datak, tx_data}, drop_octet, tx_even, frame_cnt, q[i].w, q[i].dr, exp_ev, q[i].cnt);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_frame_even();
      logic exp_ev;
      q.delete();
      add(1'b1, 1'b0, 1'b0, 8'h00, W_I, 1'b0, 16'd0);
      add_idle(W_D, 16'd0);
      add(1'b0, 1'b1, 1'b0, 8'h55, W_S, 1'b0, 16'd1);
      add_body(1, 8, -1, 16'd1);
      add_idle(W_T, 16'd1);
      add_idle(W_R, 16'd1);
      add_idle(W_I, 16'd1);
      exp_ev = 1'b0;
      foreach (q[i]) begin
         rst = q[i].rst; tx_en = q[i].en; tx_er = q[i].er; txd = q[i].d;
         @(posedge clk); #1;
         exp_ev = q[i].rst ? 1'b1 : ~exp_ev;
         checks++;
         if ({tx_datak, tx_data} !== q[i].w || drop_octet !== q[i].dr ||
             tx_even !== exp_ev || frame_cnt !== q[i].cnt) begin
            errors++;
            $display("FAIL frame_even[%0d]: got k/d=%h drop=%b even=%b cnt=%0d, want k/d=%h drop=%b even=%b cnt=%0d",
                     i, {tx_datak, tx_data}, drop_octet, tx_even, frame_cnt, q[i].w, q[i].dr, exp_ev, q[i].cnt);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_frame_odd();
      logic exp_ev;
      q.delete();
      add(1'b1, 1'b0, 1'b0, 8'h00, W_I, 1'b0, 16'd0);
      // First octet lands on an odd slot: idle continues and the octet is dropped.
      add(1'b0, 1'b1, 1'b0, 8'h55, W_D, 1'b1, 16'd0);
      add(1'b0, 1'b1, 1'b0, 8'h55, W_S, 1'b0, 16'd1);
      add_body(2, 8, -1, 16'd1);
      add_idle(W_T, 16'd1);
      add_idle(W_R, 16'd1);
      add_idle(W_R, 16'd1);
      add_idle(W_I, 16'd1);
      // 9-octet frame starting even: /T/ odd, so two /R/ before the idle.
      add_idle(W_D, 16'd1);
      add(1'b0, 1'b1, 1'b0, 8'h55, W_S, 1'b0, 16'd2);
      add_body(1, 9, -1, 16'd2);
      add_idle(W_T, 16'd2);
      add_idle(W_R, 16'd2);
      add_idle(W_R, 16'd2);
      add_idle(W_I, 16'd2);
      exp_ev = 1'b0;
      foreach (q[i]) begin
         rst = q[i].rst; tx_en = q[i].en; tx_er = q[i].er; txd = q[i].d;
         @(posedge clk); #1;
         exp_ev = q[i].rst ? 1'b1 : ~exp_ev;
         checks++;
         if ({tx_datak, tx_data} !== q[i].w || drop_octet !== q[i].dr ||
             tx_even !== exp_ev || frame_cnt !== q[i].cnt) begin
            errors++;
            $display("FAIL frame_odd[%0d]: got k/d=%h drop=%b even=%b cnt=%0d, want k/d=%h drop=%b even=%b cnt=%0d",
                     i, {tx_datak, tx_data}, drop_octet, tx_even, frame_cnt, q[i].w, q[i].dr, exp_ev, q[i].cnt);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_tx_error();
      logic exp_ev;
      q.delete();
      add(1'b1, 1'b0, 1'b0, 8'h00, W_I, 1'b0, 16'd0);
      add_idle(W_D, 16'd0);
      add(1'b0, 1'b1, 1'b0, 8'h55, W_S, 1'b0, 16'd1);
      add_body(1, 8, 4, 16'd1);
      add_idle(W_T, 16'd1);
      add_idle(W_R, 16'd1);
      add_idle(W_I, 16'd1);
      exp_ev = 1'b0;
      foreach (q[i]) begin
         rst = q[i].rst; tx_en = q[i].en; tx_er = q[i].er; txd = q[i].d;
         @(posedge clk); #1;
         exp_ev = q[i].rst ? 1'b1 : ~exp_ev;
         checks++;
         if ({tx_datak, tx_data} !== q[i].w || drop_octet !== q[i].dr ||
             tx_even !== exp_ev || frame_cnt !== q[i].cnt) begin
            errors++;
            $display("FAIL tx_error[%0d]: got k/d=%h drop=%b even=%b cnt=%0d, want k/d=%h drop=%b even=%b cnt=%0d",
                     i, {tx_datak, tx_data}, drop_octet, tx_even, frame_cnt, q[i].w, q[i].dr, exp_ev, q[i].cnt);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic exp_ev;
      q.delete();
      add(1'b1, 1'b0, 1'b0, 8'h00, W_I, 1'b0, 16'd0);
      add_idle(W_D, 16'd0);
      add(1'b0, 1'b1, 1'b0, 8'h55, W_S, 1'b0, 16'd1);
      add_body(1, 8, -1, 16'd1);
      add(1'b0, 1'b0, 1'b1, 8'h0F, W_T, 1'b0, 16'd1);
      for (int i = 0; i < 3; i++) add(1'b0, 1'b0, 1'b1, 8'h0F, W_R, 1'b0, 16'd1);
      add(1'b0, 1'b1, 1'b0, 8'h55, W_S, 1'b0, 16'd2);
      add_body(1, 8, -1, 16'd2);
      add_idle(W_T, 16'd2);
      add_idle(W_R, 16'd2);
      add_idle(W_I, 16'd2);
      exp_ev = 1'b0;
      foreach (q[i]) begin
         rst = q[i].rst; tx_en = q[i].en; tx_er = q[i].er; txd = q[i].d;
         @(posedge clk); #1;
         exp_ev = q[i].rst ? 1'b1 : ~exp_ev;
         checks++;
         if ({tx_datak, tx_data} !== q[i].w || drop_octet !== q[i].dr ||
             tx_even !== exp_ev || frame_cnt !== q[i].cnt) begin
            errors++;
            $display("FAIL back_to_back[%0d]: got k/d=%h drop=%b even=%b cnt=%0d, want k/d=%h drop=%b even=%b cnt=%0d",
                     i, {tx_datak, tx_data}, drop_octet, tx_even, frame_cnt, q[i].w, q[i].dr, exp_ev, q[i].cnt);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_extend_odd();
      logic exp_ev;
      q.delete();
      add(1'b1, 1'b0, 1'b0, 8'h00, W_I, 1'b0, 16'd0);
      add_idle(W_D, 16'd0);
      add(1'b0, 1'b1, 1'b0, 8'h55, W_S, 1'b0, 16'd1);
      add_body(1, 8, -1, 16'd1);
      add(1'b0, 1'b0, 1'b1, 8'h0F, W_T, 1'b0, 16'd1);
      add(1'b0, 1'b0, 1'b1, 8'h0F, W_R, 1'b0, 16'd1);
      // Bad extension value becomes /V/.
      add(1'b0, 1'b0, 1'b1, 8'h00, W_V, 1'b0, 16'd1);
      // Burst frame arrives on an odd slot: /R/ and drop, then /S/.
      add(1'b0, 1'b1, 1'b0, 8'h55, W_R, 1'b1, 16'd1);
      add(1'b0, 1'b1, 1'b0, 8'h55, W_S, 1'b0, 16'd2);
      add_body(2, 8, -1, 16'd2);
      add_idle(W_T, 16'd2);
      // Octets during the /R/ tail are dropped.
      add(1'b0, 1'b1, 1'b0, 8'h55, W_R, 1'b1, 16'd2);
      add(1'b0, 1'b1, 1'b0, 8'h55, W_R, 1'b1, 16'd2);
      add_idle(W_I, 16'd2);
      exp_ev = 1'b0;
      foreach (q[i]) begin
         rst = q[i].rst; tx_en = q[i].en; tx_er = q[i].er; txd = q[i].d;
         @(posedge clk); #1;
         exp_ev = q[i].rst ? 1'b1 : ~exp_ev;
         checks++;
         if ({tx_datak, tx_data} !== q[i].w || drop_octet !== q[i].dr ||
             tx_even !== exp_ev || frame_cnt !== q[i].cnt) begin
            errors++;
            $display("FAIL extend_odd[%0d]: got k/d=%h drop=%b even=%b cnt=%0d, want k/d=%h drop=%b even=%b cnt=%0d",
                     i, {tx_datak, tx_data}, drop_octet, tx_even, frame_cnt, q[i].w, q[i].dr, exp_ev, q[i].cnt);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_reset_mid_frame();
      logic exp_ev;
      q.delete();
      add(1'b1, 1'b0, 1'b0, 8'h00, W_I, 1'b0, 16'd0);
      add_idle(W_D, 16'd0);
      add(1'b0, 1'b1, 1'b0, 8'h55, W_S, 1'b0, 16'd1);
      add(1'b0, 1'b1, 1'b0, 8'h55, 9'h055, 1'b0, 16'd1);
      add(1'b0, 1'b1, 1'b0, 8'h55, 9'h055, 1'b0, 16'd1);
      add(1'b1, 1'b1, 1'b0, 8'h55, W_I, 1'b0, 16'd0);
      // New frame must wait for a full /I/ before /S/.
      add(1'b0, 1'b1, 1'b0, 8'h55, W_D, 1'b1, 16'd0);
      add(1'b0, 1'b1, 1'b0, 8'h55, W_S, 1'b0, 16'd1);
      add(1'b0, 1'b1, 1'b0, 8'hD5, 9'h0D5, 1'b0, 16'd1);
      add_idle(W_T, 16'd1);
      add_idle(W_R, 16'd1);
      add_idle(W_I, 16'd1);
      exp_ev = 1'b0;
      foreach (q[i]) begin
         rst = q[i].rst; tx_en = q[i].en; tx_er = q[i].er; txd = q[i].d;
         @(posedge clk); #1;
         exp_ev = q[i].rst ? 1'b1 : ~exp_ev;
         checks++;
         if ({tx_datak, tx_data} !== q[i].w || drop_octet !== q[i].dr ||
             tx_even !== exp_ev || frame_cnt !== q[i].cnt) begin
            errors++;
            $display("FAIL reset_mid[%0d]: got k/d=%h drop=%b even=%b cnt=%0d, want k/d=%h drop=%b even=%b cnt=%0d",
                     i, {tx_datak, tx_data}, drop_octet, tx_even, frame_cnt, q[i].w, q[i].dr, exp_ev, q[i].cnt);
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_frame_even();
      test_frame_odd();
      test_tx_error();
      test_back_to_back();
      test_extend_odd();
      test_reset_mid_frame();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
